// File: rtl/lzd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzd_norm_pipe
// Brief    : Two-stage leading/trailing-zero counter and normaliser with
//            valid/ready handshake and full backpressure.
// Revision : 1.0
// ============================================================================
module lzd_norm_pipe #(
   parameter  int W  = 8,
   localparam int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_count,
   output logic [W-1:0]  out_norm,
   output logic          out_zero,
   output logic          out_mode
);

   logic          r_s1_valid;
   logic          r_s1_mode;
   logic [W-1:0]  r_s1_data;

   logic          r_s2_valid;
   logic          r_s2_mode;
   logic          r_s2_zero;
   logic [CW-1:0] r_s2_count;
   logic [W-1:0]  r_s2_norm;

   logic          w_s1_ready;
   logic          w_s2_ready;
   logic          w_in_xfer;
   logic [CW-1:0] w_count;
   logic          w_zero;
   logic [W-1:0]  w_norm;

   assign w_s2_ready = !r_s2_valid || out_ready;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign in_ready   = w_s1_ready;
   assign w_in_xfer  = in_valid && w_s1_ready;

   // Priority encode: the last matching bit in scan order wins, so the scan
   // runs toward the bit that defines the count. All-zero falls through to W.
   always_comb begin
      w_count = CW'(W);
      if (r_s1_mode) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (r_s1_data[i]) w_count = CW'(i);
         end
      end else begin
         for (int i = 0; i < W; i++) begin
            if (r_s1_data[i]) w_count = CW'(W - 1 - i);
         end
      end
   end

   assign w_zero = ~|r_s1_data;
   assign w_norm = r_s1_mode ? (r_s1_data >> w_count) : (r_s1_data << w_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_mode  <= 1'b0;
         r_s1_data  <= '0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_mode  <= in_mode;
         r_s1_data  <= in_data;
      end else if (w_s2_ready) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_mode  <= 1'b0;
         r_s2_zero  <= 1'b0;
         r_s2_count <= '0;
         r_s2_norm  <= '0;
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_mode  <= r_s1_mode;
            r_s2_zero  <= w_zero;
            r_s2_count <= w_count;
            r_s2_norm  <= w_norm;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_count = r_s2_count;
   assign out_norm  = r_s2_norm;
   assign out_zero  = r_s2_zero;
   assign out_mode  = r_s2_mode;

endmodule
`default_nettype wire
